reduce_tree_pipe: RTL and testbench

Parametrised, pipelined bitwise reduction tree with a per-transaction operation select (AND, OR or XOR). It pads the input to a power of two with the identity element of the selected operation. Pipeline registers are inserted every `STAGE_LEVELS` tree levels, and each stage has its own valid/ready handshake, so the block can stall and collapse bubbles. It sits in the FPU rounder/normaliser path and produces sticky, zero-detect and parity bits for wide mantissa fields without limiting clock frequency.

---
 rtl/reduce_pkg.sv | 38 +++
 rtl/reduce_comb.sv | 31 +++
 rtl/reduce_tree_pipe.sv | 118 +++++++++++
 tb/tb_reduce_tree_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared types and elaboration helpers for the pipelined reduction tree.
package reduce_pkg;

   typedef enum logic [1:0] {
      OP_AND  = 2'b00,
      OP_OR   = 2'b01,
      OP_XOR  = 2'b10,
      OP_RSVD = 2'b11
   } op_t;

   // Padding bit that leaves the reduction unchanged: 1 for AND, 0 otherwise.
   function automatic logic identity(op_t op);
      return (op == OP_AND);
   endfunction

   // Two-input node of the tree; the reserved encoding behaves as OR.
   function automatic logic combine(op_t op, logic a, logic b);
      case (op)
         OP_AND:  return a & b;
         OP_XOR:  return a ^ b;
         default: return a | b;
      endcase
   endfunction

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   // Number of pipeline stages for an n-bit input with s tree levels per stage.
   function automatic int stage_count(int n, int s);
      int lv;
      int c;
      lv = $clog2(n);
      c  = (lv + s - 1) / s;
      return (c < 1) ? 1 : c;
   endfunction

endpackage

// File: rtl/reduce_comb.sv
// Combinational slice of the reduction tree: LV levels, W bits in, W>>LV bits out.
// W must be a power of two. All levels are kept in one flat vector: level l
// starts at offset 2*W - 2*(W>>l) and is W>>l bits wide.
module reduce_comb
   import reduce_pkg::*;
#(
   parameter int W  = 4,
   parameter int LV = 2
) (
   input  logic [W-1:0]        data,
   input  op_t                 op,
   output logic [(W>>LV)-1:0]  result
);

   localparam int TOT = 2 * W - (W >> LV);

   logic [TOT-1:0] tree;

   assign tree[W-1:0] = data;

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int SRC = 2 * W - 2 * (W >> l);
      localparam int DST = 2 * W - 2 * (W >> (l + 1));
      for (genvar i = 0; i < (W >> (l + 1)); i++) begin : g_node
         assign tree[DST + i] = combine(op, tree[SRC + 2 * i], tree[SRC + 2 * i + 1]);
      end
   end

   assign result = tree[TOT-1 -: (W >> LV)];

endmodule

// File: rtl/reduce_tree_pipe.sv
// Pipelined AND/OR/XOR reduction tree with identity padding and a per-stage
// valid/ready handshake so empty stages fill even while the output is stalled.
module reduce_tree_pipe
   import reduce_pkg::*;
#(
   parameter int N            = 64,
   parameter int STAGE_LEVELS = 2,
   parameter int TAG_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  op_t              in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int LEVELS = $clog2(N);
   localparam int NP     = 1 << LEVELS;
   localparam int L      = stage_count(N, STAGE_LEVELS);

   logic [NP-1:0] padded;

   assign padded[N-1:0] = in_data;
   if (NP > N) begin : g_pad
      assign padded[NP-1:N] = {(NP - N){identity(in_op)}};
   end

   for (genvar s = 0; s < L; s++) begin : g_stage
      localparam int LO = imin(LEVELS, s * STAGE_LEVELS);
      localparam int HI = imin(LEVELS, (s + 1) * STAGE_LEVELS);
      localparam int WI = NP >> LO;
      localparam int WO = NP >> HI;

      logic [WI-1:0]    src;
      op_t              src_op;
      logic [TAG_W-1:0] src_tag;
      logic             src_vld;
      logic             ready;
      logic             dn_ready;
      logic             load;
      logic [WO-1:0]    reduced;
      logic             vld_q;
      logic [WO-1:0]    data_q;
      logic [TAG_W-1:0] tag_q;

      if (s == 0) begin : g_head
         assign src      = padded;
         assign src_op   = in_op;
         assign src_tag  = in_tag;
         assign src_vld  = in_valid;
         assign in_ready = ready;
      end else begin : g_link
         assign src      = g_stage[s-1].data_q;
         assign src_op   = g_stage[s-1].g_body.op_q;
         assign src_tag  = g_stage[s-1].tag_q;
         assign src_vld  = g_stage[s-1].vld_q;
      end

      assign ready = !vld_q || dn_ready;
      assign load  = src_vld && ready;

      reduce_comb #(
         .W  (WI),
         .LV (HI - LO)
      ) u_comb (
         .data   (src),
         .op     (src_op),
         .result (reduced)
      );

      // Stage occupancy: take upstream valid whenever this stage can move.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
         end else if (ready) begin
            vld_q <= src_vld;
         end
      end

      if (s == L - 1) begin : g_tail
         assign dn_ready   = out_ready;
         assign out_valid  = vld_q;
         assign out_result = data_q[0];
         assign out_tag    = tag_q;

         // Output register: cleared on reset, updated only on a transfer.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_q <= '0;
               tag_q  <= '0;
            end else if (load) begin
               data_q <= reduced;
               tag_q  <= src_tag;
            end
         end
      end else begin : g_body
         op_t op_q;

         assign dn_ready = g_stage[s+1].ready;

         // Intermediate partial bits, op and tag, captured only on a transfer.
         always_ff @(posedge clk) begin
            if (load) begin
               data_q <= reduced;
               tag_q  <= src_tag;
               op_q   <= src_op;
            end
         end
      end
   end

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Directed bench for reduce_tree_pipe: a 64-bit instance (L=3) and a 53-bit
// instance exercising identity padding.
module tb_reduce_tree_pipe;
   import reduce_pkg::*;

   logic        clk = 1'b0;
   logic        rst;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_result;
   logic [63:0] a_in_data;
   op_t         a_in_op;
   logic [3:0]  a_in_tag, a_out_tag;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_result;
   logic [52:0] b_in_data;
   op_t         b_in_op;
   logic [3:0]  b_in_tag, b_out_tag;

   int total = 0;
   int bad   = 0;

   reduce_tree_pipe #(.N(64), .STAGE_LEVELS(2), .TAG_W(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_op(a_in_op), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_result(a_out_result), .out_tag(a_out_tag)
   );

   reduce_tree_pipe #(.N(53), .STAGE_LEVELS(2), .TAG_W(4)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_op(b_in_op), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_result(b_out_result), .out_tag(b_out_tag)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit sel, input bit v, input logic [63:0] d, input op_t op,
                        input logic [3:0] tag);
      if (!sel) begin
         a_in_valid = v; a_in_data = d; a_in_op = op; a_in_tag = tag;
      end else begin
         b_in_valid = v; b_in_data = d[52:0]; b_in_op = op; b_in_tag = tag;
      end
   endtask

   function automatic logic ovf(input bit sel);
      return sel ? b_out_valid : a_out_valid;
   endfunction

   function automatic logic resf(input bit sel);
      return sel ? b_out_result : a_out_result;
   endfunction

   function automatic logic [3:0] tagf(input bit sel);
      return sel ? b_out_tag : a_out_tag;
   endfunction

   function automatic logic rdyf(input bit sel);
      return sel ? b_in_ready : a_in_ready;
   endfunction

   // One transaction on an idle, unstalled pipe: check acceptance, latency,
   // result, tag and that the output drains the next cycle.
   task automatic send_one(input bit sel, input string nm, input logic [63:0] d,
                           input op_t op, input logic [3:0] tag, input logic exp);
      int n;
      drive(sel, 1'b1, d, op, tag);
      #1;
      check({nm, "_in_ready"}, 64'(rdyf(sel)), 64'd1);
      step();
      drive(sel, 1'b0, 64'd0, OP_AND, 4'd0);
      n = 0;
      while (!ovf(sel) && n < 10) begin
         step();
         n++;
      end
      check({nm, "_latency"}, 64'(n), 64'd2);
      check({nm, "_result"}, 64'(resf(sel)), 64'(exp));
      check({nm, "_tag"}, 64'(tagf(sel)), 64'(tag));
      step();
      check({nm, "_drained"}, 64'(ovf(sel)), 64'd0);
   endtask

   logic [63:0] vec_d [4];
   op_t         vec_op [4];
   logic        vec_r [4];
   logic [63:0] st_d [5];
   op_t         st_op [5];
   logic        st_r [5];

   initial begin
      int idx;
      int acc;
      int stale;

      rst = 1'b1;
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      drive(1'b0, 1'b0, 64'd0, OP_AND, 4'd0);
      drive(1'b1, 1'b0, 64'd0, OP_AND, 4'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset state
      check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_out_result", 64'(a_out_result), 64'd0);
      check("rst_a_out_tag", 64'(a_out_tag), 64'd0);
      check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
      check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
      step();

      // Single transactions, 64-bit instance
      send_one(1'b0, "and_ones", 64'hFFFF_FFFF_FFFF_FFFF, OP_AND, 4'd1, 1'b1);
      send_one(1'b0, "and_one_bit", 64'h1, OP_AND, 4'd2, 1'b0);
      send_one(1'b0, "or_zero", 64'h0, OP_OR, 4'd3, 1'b0);
      send_one(1'b0, "or_msb", 64'h8000_0000_0000_0000, OP_OR, 4'd4, 1'b1);
      send_one(1'b0, "xor_three", 64'h7, OP_XOR, 4'd5, 1'b1);

      // 53-bit instance: identity padding
      send_one(1'b1, "n53_and_ones", 64'h1F_FFFF_FFFF_FFFF, OP_AND, 4'd3, 1'b1);
      send_one(1'b1, "n53_xor_52", 64'h1F_FFFF_FFFF_FFFE, OP_XOR, 4'd6, 1'b0);
      send_one(1'b1, "n53_and_top0", 64'h0F_FFFF_FFFF_FFFF, OP_AND, 4'd7, 1'b0);
      send_one(1'b1, "n53_or_zero", 64'h0, OP_OR, 4'd8, 1'b0);
      send_one(1'b1, "n53_or_top", 64'h10_0000_0000_0000, OP_OR, 4'd9, 1'b1);

      // Back-to-back stream of mixed ops, tags 0..3
      vec_d[0] = 64'hFFFF_FFFF_FFFF_FFFF; vec_op[0] = OP_AND;  vec_r[0] = 1'b1;
      vec_d[1] = 64'h0;                   vec_op[1] = OP_OR;   vec_r[1] = 1'b0;
      vec_d[2] = 64'h1;                   vec_op[2] = OP_XOR;  vec_r[2] = 1'b1;
      vec_d[3] = 64'h10;                  vec_op[3] = OP_RSVD; vec_r[3] = 1'b1;
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (c < 4) begin
            drive(1'b0, 1'b1, vec_d[c], vec_op[c], 4'(c));
            #1;
            check($sformatf("b2b_in_ready%0d", c), 64'(a_in_ready), 64'd1);
         end else begin
            drive(1'b0, 1'b0, 64'd0, OP_AND, 4'd0);
         end
         step();
         if (a_out_valid && idx < 4) begin
            check($sformatf("b2b_result%0d", idx), 64'(a_out_result), 64'(vec_r[idx]));
            check($sformatf("b2b_tag%0d", idx), 64'(a_out_tag), 64'(idx));
            check($sformatf("b2b_cycle%0d", idx), 64'(c), 64'(idx + 2));
            idx++;
         end
      end
      check("b2b_count", 64'(idx), 64'd4);

      // Stall: out_ready low for 6 cycles while offering 5 inputs
      st_d[0] = 64'h0;                   st_op[0] = OP_OR;  st_r[0] = 1'b0;
      st_d[1] = 64'hFFFF_FFFF_FFFF_FFFF; st_op[1] = OP_AND; st_r[1] = 1'b1;
      st_d[2] = 64'h1;                   st_op[2] = OP_XOR; st_r[2] = 1'b1;
      st_d[3] = 64'h1;                   st_op[3] = OP_AND; st_r[3] = 1'b0;
      st_d[4] = 64'h4;                   st_op[4] = OP_OR;  st_r[4] = 1'b1;
      a_out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         idx = (acc > 3) ? 3 : acc;
         drive(1'b0, 1'b1, st_d[idx], st_op[idx], 4'(5 + idx));
         #1;
         check($sformatf("stall_in_ready%0d", c), 64'(a_in_ready), (c < 3) ? 64'd1 : 64'd0);
         if (a_in_ready) acc++;
         step();
         if (c >= 2) begin
            check($sformatf("stall_valid%0d", c), 64'(a_out_valid), 64'd1);
            check($sformatf("stall_result%0d", c), 64'(a_out_result), 64'(st_r[0]));
            check($sformatf("stall_tag%0d", c), 64'(a_out_tag), 64'd5);
         end
      end
      check("stall_accepted", 64'(acc), 64'd3);
      a_out_ready = 1'b1;
      drive(1'b0, 1'b1, st_d[3], st_op[3], 4'd8);
      #1;
      check("release_in_ready0", 64'(a_in_ready), 64'd1);
      step();
      check("release_result1", 64'(a_out_result), 64'(st_r[1]));
      check("release_tag1", 64'(a_out_tag), 64'd6);
      drive(1'b0, 1'b1, st_d[4], st_op[4], 4'd9);
      #1;
      check("release_in_ready1", 64'(a_in_ready), 64'd1);
      step();
      drive(1'b0, 1'b0, 64'd0, OP_AND, 4'd0);
      check("release_result2", 64'(a_out_result), 64'(st_r[2]));
      check("release_tag2", 64'(a_out_tag), 64'd7);
      step();
      check("release_valid3", 64'(a_out_valid), 64'd1);
      check("release_result3", 64'(a_out_result), 64'(st_r[3]));
      check("release_tag3", 64'(a_out_tag), 64'd8);
      step();
      check("release_result4", 64'(a_out_result), 64'(st_r[4]));
      check("release_tag4", 64'(a_out_tag), 64'd9);
      step();
      check("release_empty", 64'(a_out_valid), 64'd0);

      // Bubble collapse under a stalled output
      a_out_ready = 1'b0;
      drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, OP_AND, 4'hA);
      #1;
      check("bubble_in_ready_x", 64'(a_in_ready), 64'd1);
      step();
      drive(1'b0, 1'b0, 64'd0, OP_AND, 4'd0);
      step();
      step();
      check("bubble_x_valid", 64'(a_out_valid), 64'd1);
      drive(1'b0, 1'b1, 64'h3, OP_XOR, 4'hB);
      #1;
      check("bubble_in_ready_y", 64'(a_in_ready), 64'd1);
      step();
      drive(1'b0, 1'b1, 64'h2, OP_OR, 4'hC);
      #1;
      check("bubble_in_ready_z", 64'(a_in_ready), 64'd1);
      step();
      drive(1'b0, 1'b1, 64'h0, OP_OR, 4'hD);
      #1;
      check("bubble_full_in_ready", 64'(a_in_ready), 64'd0);
      drive(1'b0, 1'b0, 64'd0, OP_AND, 4'd0);
      step();
      check("bubble_hold_result", 64'(a_out_result), 64'd1);
      check("bubble_hold_tag", 64'(a_out_tag), 64'hA);
      a_out_ready = 1'b1;
      step();
      check("bubble_y_result", 64'(a_out_result), 64'd0);
      check("bubble_y_tag", 64'(a_out_tag), 64'hB);
      step();
      check("bubble_z_result", 64'(a_out_result), 64'd1);
      check("bubble_z_tag", 64'(a_out_tag), 64'hC);
      step();
      check("bubble_empty", 64'(a_out_valid), 64'd0);

      // Reset with transactions in flight
      drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, OP_AND, 4'd1);
      step();
      drive(1'b0, 1'b1, 64'h1, OP_OR, 4'd2);
      step();
      drive(1'b0, 1'b0, 64'd0, OP_AND, 4'd0);
      step();
      check("flight_valid", 64'(a_out_valid), 64'd1);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(a_out_valid), 64'd0);
      check("midrst_out_result", 64'(a_out_result), 64'd0);
      check("midrst_out_tag", 64'(a_out_tag), 64'd0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("postrst_in_ready", 64'(a_in_ready), 64'd1);
      stale = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (a_out_valid) stale++;
      end
      check("postrst_no_stale", 64'(stale), 64'd0);
      send_one(1'b0, "postrst_or_msb", 64'h8000_0000_0000_0000, OP_OR, 4'hE, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
